// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the ID/EX stage: ALU op codes, opcodes, operand-source
// selects, the decoder result and the pipeline-register layout.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_SUB  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_BGE  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1110;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        XSRC_RS1  = 2'd0,
        XSRC_PC   = 2'd1,
        XSRC_ZERO = 2'd2
    } x_src_e;

    typedef enum logic [1:0] {
        YSRC_RS2  = 2'd0,
        YSRC_IMM  = 2'd1,
        YSRC_FOUR = 2'd2
    } y_src_e;

    typedef struct packed {
        logic [3:0] control;
        x_src_e     x_src;
        y_src_e     y_src;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       illegal;
    } dec_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              branch;
        logic [2:0]        funct3;
        logic [3:0]        control;
        logic              illegal;
        x_src_e            x_src;
        y_src_e            y_src;
        logic [REG_AW-1:0] rs1_idx;
        logic [REG_AW-1:0] rs2_idx;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
    } pipe_t;

    // A bubble selects X=0 and Y=IMM=0, so the ALU sees zero operands without extra gating.
    localparam pipe_t PIPE_BUBBLE = '{
        valid:    1'b0,
        rd:       {REG_AW{1'b0}},
        regwrite: 1'b0,
        memread:  1'b0,
        memwrite: 1'b0,
        branch:   1'b0,
        funct3:   3'b000,
        control:  ALU_ADD,
        illegal:  1'b0,
        x_src:    XSRC_ZERO,
        y_src:    YSRC_IMM,
        rs1_idx:  {REG_AW{1'b0}},
        rs2_idx:  {REG_AW{1'b0}},
        rs1_data: {XLEN{1'b0}},
        rs2_data: {XLEN{1'b0}},
        pc:       {XLEN{1'b0}},
        imm:      {XLEN{1'b0}}
    };

    function automatic logic fwd_hit(input logic              we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return we & (rd != {REG_AW{1'b0}}) & (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// IF/ID-side, forwarding and ALU-side signals of the ID/EX stage, bundled as one interface.
interface id_ex_stage_if;
    import riscv_pkg::*;

    logic              valid_in;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7_b5;
    logic [XLEN-1:0]   pc_in;
    logic [REG_AW-1:0] rs1_in;
    logic [REG_AW-1:0] rs2_in;
    logic [REG_AW-1:0] rd_in;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic              flush;
    logic [REG_AW-1:0] exm_rd;
    logic              exm_we;
    logic [XLEN-1:0]   exm_res;
    logic [REG_AW-1:0] mwb_rd;
    logic              mwb_we;
    logic [XLEN-1:0]   mwb_res;

    logic [XLEN-1:0]   x;
    logic [XLEN-1:0]   y;
    logic [3:0]        control;
    logic              valid_out;
    logic [REG_AW-1:0] rd_out;
    logic              regwrite_out;
    logic              memread_out;
    logic              memwrite_out;
    logic              branch_out;
    logic [2:0]        funct3_out;
    logic [XLEN-1:0]   rs2_fwd;
    logic              stall;
    logic              illegal;

    modport master (
        output valid_in, opcode, funct3, funct7_b5, pc_in, rs1_in, rs2_in, rd_in,
               rs1_data, rs2_data, imm, flush, exm_rd, exm_we, exm_res,
               mwb_rd, mwb_we, mwb_res,
        input  x, y, control, valid_out, rd_out, regwrite_out, memread_out,
               memwrite_out, branch_out, funct3_out, rs2_fwd, stall, illegal
    );

    modport slave (
        input  valid_in, opcode, funct3, funct7_b5, pc_in, rs1_in, rs2_in, rd_in,
               rs1_data, rs2_data, imm, flush, exm_rd, exm_we, exm_res,
               mwb_rd, mwb_we, mwb_res,
        output x, y, control, valid_out, rd_out, regwrite_out, memread_out,
               memwrite_out, branch_out, funct3_out, rs2_fwd, stall, illegal
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU op, operand sources and
// control flags; unknown opcodes raise the illegal flag.
module alu_ctrl_dec
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output dec_t       dec
);

    // Arithmetic op shared by OP and OP-IMM; SUB only exists in the register form.
    function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                            input logic       b5,
                                            input logic       is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg & b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Opcode decode with safe defaults so an unrecognised opcode yields no side effects.
    always_comb begin
        dec.control  = ALU_ADD;
        dec.x_src    = XSRC_ZERO;
        dec.y_src    = YSRC_IMM;
        dec.regwrite = 1'b0;
        dec.memread  = 1'b0;
        dec.memwrite = 1'b0;
        dec.branch   = 1'b0;
        dec.illegal  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.control  = arith_op(funct3, funct7_b5, 1'b1);
                dec.x_src    = XSRC_RS1;
                dec.y_src    = YSRC_RS2;
                dec.regwrite = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.control  = arith_op(funct3, funct7_b5, 1'b0);
                dec.x_src    = XSRC_RS1;
                dec.regwrite = 1'b1;
            end
            OPC_LOAD: begin
                dec.x_src    = XSRC_RS1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
            end
            OPC_STORE: begin
                dec.x_src    = XSRC_RS1;
                dec.memwrite = 1'b1;
            end
            OPC_LUI: begin
                dec.control  = ALU_LUI;
                dec.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                dec.x_src    = XSRC_PC;
                dec.regwrite = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.x_src    = XSRC_PC;
                dec.y_src    = YSRC_FOUR;
                dec.regwrite = 1'b1;
            end
            OPC_BRANCH: begin
                dec.x_src  = XSRC_RS1;
                dec.y_src  = YSRC_RS2;
                dec.branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: dec.control = ALU_SUB;
                    3'b100:         dec.control = ALU_SLT;
                    3'b101:         dec.control = ALU_BGE;
                    3'b110, 3'b111: dec.control = ALU_SLTU;
                    default:        dec.control = ALU_ADD;
                endcase
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: captures decoded fields, detects load-use
// hazards and forwards EX/MEM and MEM/WB results into the ALU operands.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    dec_t            dec_s;
    pipe_t           pipe_d;
    pipe_t           pipe_q;
    logic            stall_s;
    logic [XLEN-1:0] rs1_fwd_s;
    logic [XLEN-1:0] rs2_fwd_s;
    logic [XLEN-1:0] x_s;
    logic [XLEN-1:0] y_s;

    alu_ctrl_dec u_dec (
        .opcode    (bus.opcode),
        .funct3    (bus.funct3),
        .funct7_b5 (bus.funct7_b5),
        .dec       (dec_s)
    );

    // A load in EX whose target is read by the instruction in IF/ID must wait one cycle.
    assign stall_s = pipe_q.valid & pipe_q.memread & (pipe_q.rd != {REG_AW{1'b0}}) &
                     bus.valid_in &
                     ((pipe_q.rd == bus.rs1_in) | (pipe_q.rd == bus.rs2_in));

    // Next pipeline contents: flush beats stall, both beat a normal capture.
    always_comb begin
        pipe_d = PIPE_BUBBLE;
        if (bus.flush) begin
            pipe_d = PIPE_BUBBLE;
        end else if (stall_s) begin
            pipe_d = PIPE_BUBBLE;
        end else if (!bus.valid_in) begin
            pipe_d = PIPE_BUBBLE;
        end else if (dec_s.illegal) begin
            pipe_d.illegal = 1'b1;
        end else begin
            pipe_d.valid    = 1'b1;
            pipe_d.rd       = bus.rd_in;
            pipe_d.regwrite = dec_s.regwrite & (bus.rd_in != {REG_AW{1'b0}});
            pipe_d.memread  = dec_s.memread;
            pipe_d.memwrite = dec_s.memwrite;
            pipe_d.branch   = dec_s.branch;
            pipe_d.funct3   = bus.funct3;
            pipe_d.control  = dec_s.control;
            pipe_d.x_src    = dec_s.x_src;
            pipe_d.y_src    = dec_s.y_src;
            pipe_d.rs1_idx  = bus.rs1_in;
            pipe_d.rs2_idx  = bus.rs2_in;
            pipe_d.rs1_data = bus.rs1_data;
            pipe_d.rs2_data = bus.rs2_data;
            pipe_d.pc       = bus.pc_in;
            pipe_d.imm      = bus.imm;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= PIPE_BUBBLE;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        rs1_fwd_s = pipe_q.rs1_data;
        rs2_fwd_s = pipe_q.rs2_data;
        if (fwd_hit(bus.exm_we, bus.exm_rd, pipe_q.rs1_idx)) begin
            rs1_fwd_s = bus.exm_res;
        end else if (fwd_hit(bus.mwb_we, bus.mwb_rd, pipe_q.rs1_idx)) begin
            rs1_fwd_s = bus.mwb_res;
        end else begin
            rs1_fwd_s = pipe_q.rs1_data;
        end
        if (fwd_hit(bus.exm_we, bus.exm_rd, pipe_q.rs2_idx)) begin
            rs2_fwd_s = bus.exm_res;
        end else if (fwd_hit(bus.mwb_we, bus.mwb_rd, pipe_q.rs2_idx)) begin
            rs2_fwd_s = bus.mwb_res;
        end else begin
            rs2_fwd_s = pipe_q.rs2_data;
        end
    end

    // Operand source selection; PC, IMM and the link constant bypass forwarding.
    always_comb begin
        x_s = {XLEN{1'b0}};
        y_s = {XLEN{1'b0}};
        case (pipe_q.x_src)
            XSRC_RS1:  x_s = rs1_fwd_s;
            XSRC_PC:   x_s = pipe_q.pc;
            XSRC_ZERO: x_s = {XLEN{1'b0}};
            default:   x_s = {XLEN{1'b0}};
        endcase
        case (pipe_q.y_src)
            YSRC_RS2:  y_s = rs2_fwd_s;
            YSRC_IMM:  y_s = pipe_q.imm;
            YSRC_FOUR: y_s = XLEN'(4);
            default:   y_s = {XLEN{1'b0}};
        endcase
    end

    assign bus.x            = x_s;
    assign bus.y            = y_s;
    assign bus.rs2_fwd      = rs2_fwd_s;
    assign bus.stall        = stall_s;
    assign bus.control      = pipe_q.control;
    assign bus.valid_out    = pipe_q.valid;
    assign bus.rd_out       = pipe_q.rd;
    assign bus.regwrite_out = pipe_q.regwrite;
    assign bus.memread_out  = pipe_q.memread;
    assign bus.memwrite_out = pipe_q.memwrite;
    assign bus.branch_out   = pipe_q.branch;
    assign bus.funct3_out   = pipe_q.funct3;
    assign bus.illegal      = pipe_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    id_ex_stage_if bus_if ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [31:0] pc);
        bus_if.valid_in  = 1'b1;
        bus_if.opcode    = opc;
        bus_if.funct3    = f3;
        bus_if.funct7_b5 = b5;
        bus_if.rs1_in    = rs1;
        bus_if.rs2_in    = rs2;
        bus_if.rd_in     = rd;
        bus_if.rs1_data  = d1;
        bus_if.rs2_data  = d2;
        bus_if.imm       = imm;
        bus_if.pc_in     = pc;
    endtask

    task automatic set_fwd(input logic [4:0] erd, input logic ewe, input logic [31:0] eres,
                           input logic [4:0] mrd, input logic mwe, input logic [31:0] mres);
        bus_if.exm_rd  = erd;
        bus_if.exm_we  = ewe;
        bus_if.exm_res = eres;
        bus_if.mwb_rd  = mrd;
        bus_if.mwb_we  = mwe;
        bus_if.mwb_res = mres;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus_if.flush = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'd0);
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
        tick();
        tick();
        check_eq("rst_valid", {31'd0, bus_if.valid_out}, 32'd0);
        check_eq("rst_control", {28'd0, bus_if.control}, 32'd0);
        check_eq("rst_x", bus_if.x, 32'd0);
        check_eq("rst_y", bus_if.y, 32'd0);
        check_eq("rst_stall", {31'd0, bus_if.stall}, 32'd0);
        check_eq("rst_regwrite", {31'd0, bus_if.regwrite_out}, 32'd0);
        reset = 1'b0;

        // SUB x3, x1, x2
        drive(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'd0);
        tick();
        check_eq("sub_control", {28'd0, bus_if.control}, 32'h7);
        check_eq("sub_x", bus_if.x, 32'd10);
        check_eq("sub_y", bus_if.y, 32'd3);
        check_eq("sub_valid", {31'd0, bus_if.valid_out}, 32'd1);
        check_eq("sub_rd", {27'd0, bus_if.rd_out}, 32'd3);

        // ADDI with B5 set is still ADD
        drive(7'b0010011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd5, 32'd0);
        tick();
        check_eq("addi_control", {28'd0, bus_if.control}, 32'h0);
        check_eq("addi_y", bus_if.y, 32'd5);

        // Forwarding on rs1 of ADD x3, x1, x2
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'd0);
        tick();
        set_fwd(5'd1, 1'b1, 32'd99, 5'd1, 1'b1, 32'd55);
        #1;
        check_eq("fwd_exm", bus_if.x, 32'd99);
        bus_if.exm_we = 1'b0;
        #1;
        check_eq("fwd_mwb", bus_if.x, 32'd55);
        bus_if.exm_we = 1'b1;
        bus_if.exm_rd = 5'd0;
        #1;
        check_eq("fwd_exm_x0", bus_if.x, 32'd55);
        bus_if.mwb_we = 1'b0;
        #1;
        check_eq("fwd_none", bus_if.x, 32'd10);
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

        // LW x5, 8(x1) followed by ADD x6, x5, x7
        drive(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5, 32'd10, 32'd0, 32'd8, 32'd0);
        tick();
        check_eq("lw_memread", {31'd0, bus_if.memread_out}, 32'd1);
        check_eq("lw_x", bus_if.x, 32'd10);
        check_eq("lw_y", bus_if.y, 32'd8);
        drive(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd7, 5'd6, 32'd0, 32'd7, 32'd0, 32'd0);
        #1;
        check_eq("lu_stall", {31'd0, bus_if.stall}, 32'd1);
        tick();
        check_eq("lu_bubble_valid", {31'd0, bus_if.valid_out}, 32'd0);
        check_eq("lu_bubble_ctrl", {28'd0, bus_if.control}, 32'd0);
        check_eq("lu_stall_once", {31'd0, bus_if.stall}, 32'd0);
        set_fwd(5'd0, 1'b0, 32'd0, 5'd5, 1'b1, 32'd77);
        tick();
        check_eq("lu_add_valid", {31'd0, bus_if.valid_out}, 32'd1);
        check_eq("lu_add_x", bus_if.x, 32'd77);
        check_eq("lu_add_y", bus_if.y, 32'd7);
        check_eq("lu_add_stall", {31'd0, bus_if.stall}, 32'd0);
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

        // BGE, then BEQ flushed
        drive(7'b1100011, 3'b101, 1'b0, 5'd1, 5'd2, 5'd0, 32'd10, 32'd3, 32'd0, 32'd0);
        tick();
        check_eq("bge_control", {28'd0, bus_if.control}, 32'hB);
        check_eq("bge_branch", {31'd0, bus_if.branch_out}, 32'd1);
        check_eq("bge_regwrite", {31'd0, bus_if.regwrite_out}, 32'd0);
        drive(7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd10, 32'd3, 32'd0, 32'd0);
        bus_if.flush = 1'b1;
        tick();
        check_eq("flush_valid", {31'd0, bus_if.valid_out}, 32'd0);
        check_eq("flush_control", {28'd0, bus_if.control}, 32'd0);
        check_eq("flush_branch", {31'd0, bus_if.branch_out}, 32'd0);
        bus_if.flush = 1'b0;

        // Flush together with a load-use hazard
        drive(7'b0000011, 3'b010, 1'b0, 5'd1, 5'd0, 5'd5, 32'd10, 32'd0, 32'd8, 32'd0);
        tick();
        drive(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd7, 5'd6, 32'd0, 32'd7, 32'd0, 32'd0);
        bus_if.flush = 1'b1;
        #1;
        check_eq("fs_stall", {31'd0, bus_if.stall}, 32'd1);
        tick();
        check_eq("fs_valid", {31'd0, bus_if.valid_out}, 32'd0);
        bus_if.flush = 1'b0;
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd4, 32'd10, 32'd3, 32'd0, 32'd0);
        tick();
        check_eq("fs_next_valid", {31'd0, bus_if.valid_out}, 32'd1);
        check_eq("fs_next_x", bus_if.x, 32'd10);

        // Unknown opcode, then LUI
        drive(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd4, 32'd10, 32'd3, 32'd0, 32'd0);
        tick();
        check_eq("ill_valid", {31'd0, bus_if.valid_out}, 32'd0);
        check_eq("ill_flag", {31'd0, bus_if.illegal}, 32'd1);
        drive(7'b0110111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'h12345000, 32'd0);
        tick();
        check_eq("ill_pulse", {31'd0, bus_if.illegal}, 32'd0);
        check_eq("lui_control", {28'd0, bus_if.control}, 32'h6);
        check_eq("lui_y", bus_if.y, 32'h12345000);
        check_eq("lui_regwrite", {31'd0, bus_if.regwrite_out}, 32'd1);

        // JAL link, AUIPC, SRA, SRAI
        drive(7'b1101111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd1, 32'd10, 32'd3, 32'h40, 32'h100);
        tick();
        check_eq("jal_x", bus_if.x, 32'h100);
        check_eq("jal_y", bus_if.y, 32'd4);
        drive(7'b0010111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd9, 32'd10, 32'd3, 32'h1000, 32'h200);
        tick();
        check_eq("auipc_x", bus_if.x, 32'h200);
        check_eq("auipc_y", bus_if.y, 32'h1000);
        drive(7'b0110011, 3'b101, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'd0);
        tick();
        check_eq("sra_control", {28'd0, bus_if.control}, 32'hE);
        drive(7'b0010011, 3'b101, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd2, 32'd0);
        tick();
        check_eq("srai_control", {28'd0, bus_if.control}, 32'hE);

        // ADD to x0 keeps valid but drops REGWRITE
        drive(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd10, 32'd3, 32'd0, 32'd0);
        tick();
        check_eq("x0_valid", {31'd0, bus_if.valid_out}, 32'd1);
        check_eq("x0_regwrite", {31'd0, bus_if.regwrite_out}, 32'd0);

        // SW x2, 16(x1) with rs2 forwarded from EX/MEM
        drive(7'b0100011, 3'b010, 1'b0, 5'd1, 5'd2, 5'd0, 32'd10, 32'd3, 32'd16, 32'd0);
        tick();
        set_fwd(5'd2, 1'b1, 32'h55, 5'd0, 1'b0, 32'd0);
        #1;
        check_eq("sw_rs2fwd", bus_if.rs2_fwd, 32'h55);
        check_eq("sw_y", bus_if.y, 32'd16);
        check_eq("sw_memwrite", {31'd0, bus_if.memwrite_out}, 32'd1);
        check_eq("sw_funct3", {29'd0, bus_if.funct3_out}, 32'd2);
        set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);

        // Nothing valid in IF/ID
        bus_if.valid_in = 1'b0;
        tick();
        check_eq("novalid_valid", {31'd0, bus_if.valid_out}, 32'd0);
        check_eq("novalid_x", bus_if.x, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
